// File: rtl/instr_feeder_pkg.sv
// ---------------------------------------------------------------------------
// instr_feeder_pkg
// Shared definitions for the instruction feeder that drives the 4-phase bus
// processor:
//   - opcode constants of the processor instruction set
//   - bit positions of the fields inside a 14-bit instruction word
//   - FSM state encoding of the feeder
//   - width of the processor step-counter mirror
// ---------------------------------------------------------------------------
package instr_feeder_pkg;

    // Processor opcodes (F field)
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    // Instruction word layout: [13:12]=F, [11:10]=Rx, [9:8]=Ry, [7:0]=data
    localparam int INSTR_W = 14;
    localparam int F_HI    = 13;
    localparam int F_LO    = 12;
    localparam int RX_HI   = 11;
    localparam int RX_LO   = 10;
    localparam int RY_HI   = 9;
    localparam int RY_LO   = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;

    // Same layout as a packed struct, so field access is by name in the RTL
    typedef struct packed {
        logic [1:0] f;
        logic [1:0] rx;
        logic [1:0] ry;
        logic [7:0] data;
    } instr_t;

    // Feeder FSM encoding
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [ST_W-1:0] ST_ERR   = 2'd3;

    // Processor step counter mirror
    localparam int PH_W = 2;
    localparam logic [PH_W-1:0] PH_LAST = '1;

endpackage

// File: rtl/instr_feeder_phase_mirror.sv
// ---------------------------------------------------------------------------
// instr_feeder_phase_mirror
// Copy of the processor's 2-bit step counter (T0..T3). It shares clk and
// reset with the processor and applies the same clear rule, so its value is
// always equal to the processor's current step.
// Ports:
//   clk   in  : clock, rising edge
//   reset in  : synchronous active-high reset
//   w     in  : processor w as driven by the feeder
//   done  in  : processor Done
//   ph    out : current processor step (0 = T0)
// ---------------------------------------------------------------------------
module instr_feeder_phase_mirror
    import instr_feeder_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            w,
    input  logic            done,
    output logic [PH_W-1:0] ph
);

    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_d;

    // Done always returns the processor to T0; an idle T3 also wraps to T0.
    always_comb begin
        ph_d = ph_q + PH_W'(1);
        if (done || (!w && (ph_q == PH_LAST))) begin
            ph_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign ph = ph_q;

endmodule

// File: rtl/instr_feeder.sv
// ---------------------------------------------------------------------------
// instr_feeder
// Small program sequencer for the 4-phase bus processor. A program of
// {F, Rx, Ry, data} words is loaded into a DEPTH-entry memory and run from
// entry 0 to last_addr, one instruction per processor Done. w is raised only
// while the processor sits in T0; a run that waits TMO cycles without Done
// is abandoned with a sticky err.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   load_en/addr/instr    : program memory write (ignored while busy)
//   start, last_addr      : begin a run over mem[0..last_addr] (ignored while busy)
//   Done                  : processor completion
//   w, F, Rx, Ry, data    : processor instruction inputs
//   busy                  : run in progress
//   finished              : one-cycle pulse after the last instruction's Done
//   err                   : sticky timeout flag, cleared by reset or start
//   pc                    : index of the current instruction
// ---------------------------------------------------------------------------
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TMO   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic               start,
    input  logic [AW-1:0]      last_addr,
    input  logic               Done,
    output logic               w,
    output logic [1:0]         F,
    output logic [1:0]         Rx,
    output logic [1:0]         Ry,
    output logic [7:0]         data,
    output logic               busy,
    output logic               finished,
    output logic               err,
    output logic [AW-1:0]      pc
);

    // Timeout counter counts WAIT cycles 0..TMO-1
    localparam int TW = (TMO < 2) ? 1 : $clog2(TMO);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    logic [ST_W-1:0] state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   last_q, last_d;
    instr_t          instr_q, instr_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            fin_q, fin_d;

    logic [PH_W-1:0] ph;
    logic            idle_like;
    logic [AW-1:0]   pc_inc;

    // Program memory: plain flop array, combinational read, never reset
    instr_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            mem_q[load_addr] <= instr_t'(load_instr);
        end
    end

    instr_feeder_phase_mirror u_phase (
        .clk   (clk),
        .reset (reset),
        .w     (w),
        .done  (Done),
        .ph    (ph)
    );

    // w depends on flops only, so it is stable for the whole T0 cycle
    assign w         = (state_q == ST_ISSUE) && (ph == '0);
    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_ERR);
    assign pc_inc    = pc_q + AW'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        instr_d = instr_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        fin_d   = 1'b0;

        if (idle_like) begin
            // A same-cycle write to entry 0 lands after this read, so the
            // first fetch sees the old word.
            if (start) begin
                pc_d    = '0;
                last_d  = last_addr;
                instr_d = mem_q[0];
                err_d   = 1'b0;
                state_d = ST_ISSUE;
            end
        end else if (state_q == ST_ISSUE) begin
            if (w) begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
        end else begin
            // ST_WAIT: fields hold until Done is seen
            if (Done) begin
                if (pc_q == last_q) begin
                    fin_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Done also clears the processor to T0, so the next
                    // word goes out on w in the very next cycle.
                    pc_d    = pc_inc;
                    instr_d = mem_q[pc_inc];
                    state_d = ST_ISSUE;
                end
            end else if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = ST_ERR;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            last_q  <= '0;
            instr_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
        end
    end

    assign F        = instr_q.f;
    assign Rx       = instr_q.rx;
    assign Ry       = instr_q.ry;
    assign data     = instr_q.data;
    assign finished = fin_q;
    assign err      = err_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_instr_feeder.sv
// ---------------------------------------------------------------------------
// tb_instr_feeder
// Drives instr_feeder with directed and random programs. A behavioural model
// of the 4-phase processor answers w with Done (T1 for load/move, T3 for
// add/sub) and keeps its own register file. Each accepted start pushes the
// expected instruction sequence into a queue; the negedge monitor pops one
// entry per observed w and compares.
// ---------------------------------------------------------------------------
module tb_instr_feeder;
    import instr_feeder_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               load_en = 1'b0;
    logic [AW-1:0]      load_addr = '0;
    logic [INSTR_W-1:0] load_instr = '0;
    logic               start = 1'b0;
    logic [AW-1:0]      last_addr = '0;
    logic               Done = 1'b0;
    logic               w;
    logic [1:0]         F, Rx, Ry;
    logic [7:0]         data;
    logic               busy, finished, err;
    logic [AW-1:0]      pc;

    instr_feeder #(.DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_instr(load_instr), .start(start), .last_addr(last_addr),
        .Done(Done), .w(w), .F(F), .Rx(Rx), .Ry(Ry), .data(data),
        .busy(busy), .finished(finished), .err(err), .pc(pc)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state
    logic [13:0] shadow [DEPTH];
    logic [7:0]  preg [4];
    logic [7:0]  exp_regs [4];
    logic [13:0] exp_q [$];

    // Processor model state
    int          step = 0;
    bit          active = 1'b0;
    logic [13:0] cur = '0;
    int          age = 0;
    int          lat = 0;
    bit          done_next = 1'b0;
    bit          done_kill = 1'b0;
    bit          expect_w = 1'b0;
    bit          expect_fin = 1'b0;
    int          w_seen = 0;
    int          fin_seen = 0;
    int          last_w_cyc = 0;
    int          st_cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end else begin
            $display("[TB] ok %s = %0h", nm, act);
        end
    endtask

    task automatic bound_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: actual timeout required event (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [7:0] alu(input logic [13:0] iw, input logic [7:0] a, input logic [7:0] b);
        case (iw[F_HI:F_LO])
            OP_LOAD: return iw[DATA_HI:DATA_LO];
            OP_MOVE: return b;
            OP_ADD:  return a + b;
            default: return a - b;
        endcase
    endfunction

    // Done for the next cycle, decided by the model on the previous negedge
    always @(posedge clk) begin
        #1;
        Done = done_next && !done_kill;
    end

    // Processor model + scoreboard monitor
    always @(negedge clk) begin
        logic [13:0] bus;
        logic [13:0] e;
        int step_n;
        bus = {F, Rx, Ry, data};
        if (reset) begin
            step = 0; active = 0; done_next = 0; expect_w = 0; expect_fin = 0;
            for (int i = 0; i < 4; i++) preg[i] = '0;
        end else begin
            if (Done) step_n = 0;
            else if (!w && step == 3) step_n = 0;
            else step_n = step + 1;

            if (expect_w) check("b2b_issue", w, 1'b1);
            expect_w = 0;
            check("finished", finished, expect_fin);
            if (finished) begin
                fin_seen++;
                check("fin_queue_empty", exp_q.size(), 0);
                check("fin_busy", busy, 1'b0);
                for (int i = 0; i < 4; i++) check($sformatf("fin_R%0d", i), preg[i], exp_regs[i]);
            end
            expect_fin = 0;

            if (!busy) active = 0;
            if (w) begin
                check("w_at_T0", step, 0);
                w_seen++;
                last_w_cyc = cyc;
                if (exp_q.size() == 0) begin
                    bound_fail("unexpected_issue");
                end else begin
                    e = exp_q.pop_front();
                    check("issue_word", bus, e);
                end
                cur = bus; active = 1; age = 1;
                lat = (bus[F_HI:F_LO] == OP_LOAD || bus[F_HI:F_LO] == OP_MOVE) ? 1 : 3;
                done_next = (lat == 1);
            end else if (active) begin
                if (bus !== cur) check("field_hold", bus, cur);
                if (Done) begin
                    preg[cur[RX_HI:RX_LO]] = alu(cur, preg[cur[RX_HI:RX_LO]], preg[cur[RY_HI:RY_LO]]);
                    active = 0; done_next = 0;
                    if (exp_q.size() > 0) expect_w = 1;
                    else expect_fin = 1;
                end else begin
                    age++;
                    done_next = (age == lat);
                end
            end else begin
                done_next = 0;
            end
            step = step_n;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string nm);
        check(nm, {w, F, Rx, Ry, data, busy, finished, err, pc}, '0);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [13:0] iw);
        load_en = 1; load_addr = a; load_instr = iw;
        tick();
        load_en = 0;
        shadow[a] = iw;
    endtask

    task automatic start_run(input logic [AW-1:0] last);
        logic [13:0] iw;
        for (int i = 0; i < 4; i++) exp_regs[i] = preg[i];
        for (int i = 0; i <= int'(last); i++) begin
            iw = shadow[i];
            exp_q.push_back(iw);
            exp_regs[iw[RX_HI:RX_LO]] = alu(iw, exp_regs[iw[RX_HI:RX_LO]], exp_regs[iw[RY_HI:RY_LO]]);
        end
        start = 1; last_addr = last; st_cyc = cyc;
        tick();
        start = 0;
    endtask

    task automatic wait_finish(input int budget);
        int f0 = fin_seen;
        int n = 0;
        while (fin_seen == f0 && n < budget) begin tick(); n++; end
        if (fin_seen == f0) bound_fail("run_finish");
        check("idle_after_run", busy, 1'b0);
    endtask

    task automatic wait_w(input string nm);
        int w0 = w_seen;
        int n = 0;
        while (w_seen == w0 && n < 12) begin tick(); n++; end
        if (w_seen == w0) bound_fail(nm);
    endtask

    initial begin
        int w0, f0, n, wc, p, lim;
        int phases [4];
        logic [AW-1:0] last;
        phases = '{2, 3, 0, 1};

        tick(3);
        reset = 0;
        check_reset_outs("reset_outs");

        // Directed ADD program: R0=2A, R1=55, R1=R1+R0
        load(0, {OP_LOAD, 2'd0, 2'd0, 8'h2A});
        load(1, {OP_LOAD, 2'd1, 2'd0, 8'h55});
        load(2, {OP_ADD,  2'd1, 2'd0, 8'h00});
        w0 = w_seen; f0 = fin_seen;
        start_run(2);
        wait_finish(30);
        tick(2);
        check("add_w_count", w_seen - w0, 3);
        check("add_fin_count", fin_seen - f0, 1);
        check("add_result", preg[1], 8'h7F);

        // Same program with SUB
        load(2, {OP_SUB, 2'd1, 2'd0, 8'h00});
        start_run(2);
        wait_finish(30);
        check("sub_result", preg[1], 8'h2B);

        // start and load_en while busy are ignored
        w0 = w_seen;
        start_run(2);
        wait_w("busy_first_w");
        start = 1; load_en = 1; load_addr = 0; load_instr = 14'h3FFF; last_addr = 0;
        tick();
        start = 0; load_en = 0; last_addr = 2;
        wait_finish(30);
        check("busy_w_count", w_seen - w0, 3);
        start_run(2);
        wait_finish(30);
        check("busy_sub_result", preg[1], 8'h2B);

        // Timeout with Done tied low
        done_kill = 1;
        start_run(2);
        wait_w("tmo_w");
        wc = last_w_cyc;
        n = 0;
        while (!err && n < 20) begin tick(); n++; end
        if (!err) bound_fail("tmo_err");
        else check("tmo_latency", cyc - wc, TMO + 1);
        check("tmo_busy", busy, 1'b0);
        check("tmo_state", dut.state_q, ST_ERR);
        done_kill = 0;
        exp_q.delete();
        tick();
        start_run(2);
        check("err_cleared", err, 1'b0);
        wait_finish(30);

        // Reset during WAIT of entry 1
        start_run(2);
        n = 0;
        while (!(busy && !w && pc == 1) && n < 30) begin tick(); n++; end
        if (n >= 30) bound_fail("reach_wait_pc1");
        reset = 1;
        tick();
        reset = 0;
        exp_q.delete();
        check_reset_outs("midrun_reset_outs");
        start_run(2);
        wait_finish(30);
        check("rerun_result", preg[1], 8'h2B);

        // Start at each processor phase: w must wait for T0
        foreach (phases[k]) begin
            p = phases[k];
            n = 0;
            while (step != p && n < 8) begin tick(); n++; end
            w0 = w_seen;
            start_run(0);
            wait_w("phase_w");
            check($sformatf("start_to_w_ph%0d", p), last_w_cyc - st_cyc, 1 + ((3 - p) % 4));
            wait_finish(20);
        end

        // Load and start in the same cycle: first fetch sees old mem[0]
        load_en = 1; load_addr = 0; load_instr = {OP_LOAD, 2'd2, 2'd0, 8'hC3};
        start_run(1);
        load_en = 0;
        shadow[0] = {OP_LOAD, 2'd2, 2'd0, 8'hC3};
        wait_finish(30);
        start_run(0);
        wait_finish(20);
        check("new_word_result", preg[2], 8'hC3);

        // Random programs
        for (int r = 0; r < 8; r++) begin
            last = (r == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, DEPTH - 1));
            lim = (r == 0) ? DEPTH - 1 : int'(last);
            for (int i = 0; i <= lim; i++) begin
                if (r == 0 || $urandom_range(0, 1) == 1)
                    load(AW'(i), 14'($urandom_range(0, 16383)));
            end
            tick($urandom_range(0, 3));
            start_run(last);
            wait_finish((int'(last) + 1) * 6 + 10);
        end

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog");
    end

endmodule
